// File: rtl/mod3_req_scheduler.sv
// ---------------------------------------------------------------------------
// mod3_req_scheduler
//
// Shares one bit-serial mod-3 residue engine between NREQ requesters. A
// round-robin arbiter picks one valid requester while idle, captures its
// WIDTH-bit operand and shifts it MSB-first through the residue engine, one
// bit every TICK_DIV clocks. The verdict (divisible by 3), the residue and the
// requester index are then presented on a valid/ready result port.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-high; aborts any operation in flight
//   req_valid    [NREQ]        per-requester operand valid
//   req_data     [NREQ*WIDTH]  operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready    [NREQ]        one-hot accept, only ever high while idle
//   res_valid    result available, held until accepted
//   res_ready    consumer accepts result
//   res_div3     1 when operand mod 3 == 0
//   res_residue  operand mod 3 (0..2)
//   res_id       [IDW] index of the requester that supplied the operand
//   busy         high whenever the engine is not idle
// ---------------------------------------------------------------------------
module mod3_req_scheduler #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 4,
  parameter int IDW      = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_div3,
  output logic [1:0]            res_residue,
  output logic [IDW-1:0]        res_id,
  output logic                  busy
);

  localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BCW = $clog2(WIDTH + 1);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
  localparam logic [BCW-1:0] BITS_INIT = BCW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_REPORT} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDW-1:0]   r_ptr;
  logic [1:0]       r_residue;
  logic [TCW-1:0]   r_tick;
  logic [BCW-1:0]   r_bits;
  logic [WIDTH-1:0] r_shift;
  logic             r_res_valid;
  logic             r_res_div3;
  logic [1:0]       r_res_residue;
  logic [IDW-1:0]   r_res_id;

  logic [2*NREQ-1:0] w_valid2;
  logic [NREQ-1:0]   w_rot;
  logic              w_found;
  logic [IDW-1:0]    w_grant;
  logic [IDW:0]      w_sum;
  logic [IDW:0]      w_pn;
  logic [IDW-1:0]    w_ptr_next;
  logic [WIDTH-1:0]  w_data;
  logic              w_tick_last;
  logic              w_last_bit;
  logic [1:0]        w_res_next;

  // Round-robin search: rotate the valid vector so bit k is requester
  // (ptr+k) mod NREQ, take the lowest set bit, then map back to an index.
  always_comb begin
    w_valid2 = {req_valid, req_valid};
    w_rot    = NREQ'(w_valid2 >> r_ptr);
    w_found  = 1'b0;
    w_grant  = '0;
    w_sum    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + (IDW+1)'(k);
        if (w_sum >= (IDW+1)'(NREQ)) begin
          w_sum = w_sum - (IDW+1)'(NREQ);
        end
        w_grant = w_sum[IDW-1:0];
      end
    end
  end

  // Pointer moves to the requester after the one granted, with wrap.
  always_comb begin
    w_pn = {1'b0, w_grant} + (IDW+1)'(1);
    if (w_pn >= (IDW+1)'(NREQ)) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = w_pn[IDW-1:0];
    end
  end

  always_comb begin
    w_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant == IDW'(k)) begin
        w_data = req_data[k*WIDTH +: WIDTH];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = ~reset & (r_state == S_IDLE) & w_found &
                             (w_grant == IDW'(gi));
    end
  endgenerate

  assign w_tick_last = (r_tick == TICK_LAST);
  assign w_last_bit  = w_tick_last && (r_bits == BCW'(1));

  // Residue step r' = (2r + b) mod 3; the register can never reach 3.
  always_comb begin
    case ({r_residue, r_shift[WIDTH-1]})
      3'b000:  w_res_next = 2'd0;
      3'b001:  w_res_next = 2'd1;
      3'b010:  w_res_next = 2'd2;
      3'b011:  w_res_next = 2'd0;
      3'b100:  w_res_next = 2'd1;
      3'b101:  w_res_next = 2'd2;
      default: w_res_next = 2'd0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_state_next = S_SHIFT;
      S_SHIFT:  if (w_last_bit) w_state_next = S_REPORT;
      S_REPORT: if (res_ready) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr         <= '0;
      r_residue     <= '0;
      r_tick        <= '0;
      r_bits        <= '0;
      r_shift       <= '0;
      r_res_valid   <= 1'b0;
      r_res_div3    <= 1'b0;
      r_res_residue <= '0;
      r_res_id      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_shift   <= w_data;
            r_bits    <= BITS_INIT;
            r_residue <= '0;
            r_tick    <= '0;
            r_res_id  <= w_grant;
            r_ptr     <= w_ptr_next;
          end
        end
        S_SHIFT: begin
          r_tick <= w_tick_last ? '0 : r_tick + TCW'(1);
          if (w_tick_last) begin
            r_residue <= w_res_next;
            r_shift   <= r_shift << 1;
            r_bits    <= r_bits - BCW'(1);
            if (r_bits == BCW'(1)) begin
              r_res_valid   <= 1'b1;
              r_res_residue <= w_res_next;
              r_res_div3    <= (w_res_next == 2'd0);
            end
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_valid   = r_res_valid;
  assign res_div3    = r_res_div3;
  assign res_residue = r_res_residue;
  assign res_id      = r_res_id;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mod3_req_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mod3_req_scheduler
//
// Scoreboard bench. Stimulus issues batches of requests; a round-robin model
// predicts the service order and residues and pushes them into a queue. A
// monitor pops and compares on every accepted result, and also checks grant
// legality, result latency and result stability under backpressure.
// A second instance (NREQ=1, TICK_DIV=1) is swept over all 8-bit operands.
// ---------------------------------------------------------------------------
module tb_mod3_req_scheduler;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int TICK_DIV = 4;
  localparam int IDW      = 2;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  res_valid;
  logic                  res_ready;
  logic                  res_div3;
  logic [1:0]            res_residue;
  logic [IDW-1:0]        res_id;
  logic                  busy;

  logic       f_req_valid;
  logic [7:0] f_req_data;
  logic       f_req_ready;
  logic       f_res_valid;
  logic       f_res_ready;
  logic       f_res_div3;
  logic [1:0] f_res_residue;
  logic       f_res_id;
  logic       f_busy;

  always #5 clock = ~clock;

  mod3_req_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .IDW(IDW)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_div3(res_div3),
    .res_residue(res_residue), .res_id(res_id), .busy(busy)
  );

  mod3_req_scheduler #(.NREQ(1), .WIDTH(8), .TICK_DIV(1), .IDW(1)) u_fast (
    .clock(clock), .reset(reset),
    .req_valid(f_req_valid), .req_data(f_req_data), .req_ready(f_req_ready),
    .res_valid(f_res_valid), .res_ready(f_res_ready), .res_div3(f_res_div3),
    .res_residue(f_res_residue), .res_id(f_res_id), .busy(f_busy)
  );

  typedef struct {
    int id;
    int residue;
  } exp_t;

  exp_t exp_q[$];
  int   f_exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_ptr  = 0;
  int   hold_left = 0;
  bit   rnd_ready = 0;

  // Reference model: serve the pending set round-robin starting at the
  // model pointer; each served requester moves the pointer past itself.
  function automatic void model_batch(input logic [3:0] mask, input logic [31:0] dat);
    logic [3:0] pend;
    bit         done;
    exp_t       e;
    pend = mask;
    while (pend != 0) begin
      done = 0;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (!done && pend[i]) begin
          e.id      = i;
          e.residue = int'(dat[i*WIDTH +: WIDTH]) % 3;
          exp_q.push_back(e);
          pend[i] = 1'b0;
          m_ptr   = (i + 1) % NREQ;
          done    = 1;
        end
      end
    end
  endfunction

  // Result consumer: optional forced stall, otherwise always or randomly ready.
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (res_valid && hold_left > 0) begin
        res_ready = 1'b0;
        hold_left--;
      end else begin
        res_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int             acc_edge = 0;
  logic           prev_valid = 1'b0;
  logic           prev_ready = 1'b0;
  logic           prev_div3 = 1'b0;
  logic [1:0]     prev_res = 2'd0;
  logic [IDW-1:0] prev_id = '0;
  exp_t           m_e;

  always @(negedge clock) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      checks++;
      if ($countones(req_ready) > 1 || (busy && req_ready != 0) ||
          (req_ready & ~req_valid) != 0) begin
        errors++;
        $display("FAIL grant: req_ready=%b req_valid=%b busy=%b, required one-hot subset of valid and zero while busy",
                 req_ready, req_valid, busy);
      end
      if ((req_valid & req_ready) != 0) acc_edge = cyc + 1;
      if (res_valid && !prev_valid) begin
        checks++;
        if (cyc - acc_edge != WIDTH*TICK_DIV || !busy) begin
          errors++;
          $display("FAIL latency: %0d edges busy=%b, required %0d edges busy=1",
                   cyc - acc_edge, busy, WIDTH*TICK_DIV);
        end
      end
      if (prev_valid && !prev_ready) begin
        checks++;
        if (!res_valid || res_id != prev_id || res_residue != prev_res || res_div3 != prev_div3) begin
          errors++;
          $display("FAIL hold: valid=%b id=%0d res=%0d div3=%b, required valid=1 id=%0d res=%0d div3=%b",
                   res_valid, res_id, res_residue, res_div3, prev_id, prev_res, prev_div3);
        end
      end
      if (res_valid && res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: id=%0d res=%0d, required no result", res_id, res_residue);
        end else begin
          m_e = exp_q.pop_front();
          $display("RESULT id=%0d residue=%0d div3=%b (model id=%0d residue=%0d)",
                   res_id, res_residue, res_div3, m_e.id, m_e.residue);
          if (int'(res_id) != m_e.id || int'(res_residue) != m_e.residue ||
              res_div3 != (m_e.residue == 0)) begin
            errors++;
            $display("FAIL result: id=%0d res=%0d div3=%b, required id=%0d res=%0d div3=%b",
                     res_id, res_residue, res_div3, m_e.id, m_e.residue, (m_e.residue == 0));
          end
        end
      end
      prev_valid = res_valid;
      prev_ready = res_ready;
      prev_div3  = res_div3;
      prev_res   = res_residue;
      prev_id    = res_id;
    end
  end

  int f_e;
  always @(negedge clock) begin
    if (!reset && f_res_valid && f_res_ready) begin
      checks++;
      if (f_exp_q.size() == 0) begin
        errors++;
        $display("FAIL fast_unexpected: res=%0d, required no result", f_res_residue);
      end else begin
        f_e = f_exp_q.pop_front();
        if (int'(f_res_residue) != f_e || f_res_div3 != (f_e == 0) || f_res_id != 1'b0) begin
          errors++;
          $display("FAIL fast_result: res=%0d div3=%b id=%0d, required res=%0d div3=%b id=0",
                   f_res_residue, f_res_div3, f_res_id, f_e, (f_e == 0));
        end
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if (res_valid || res_div3 || res_residue != 0 || res_id != 0 || busy ||
        req_ready != 0 || f_res_valid || f_busy || f_req_ready) begin
      errors++;
      $display("FAIL %s: valid=%b div3=%b res=%0d id=%0d busy=%b ready=%b, required all zero",
               name, res_valid, res_div3, res_residue, res_id, busy, req_ready);
    end
  endtask

  task automatic run_batch(input logic [3:0] mask, input logic [31:0] dat);
    logic [3:0] hs;
    logic [3:0] acc;
    int         c;
    model_batch(mask, dat);
    $display("BATCH mask=%b data=%h", mask, dat);
    req_data  = dat;
    req_valid = mask;
    acc       = '0;
    for (c = 0; c < 3000; c++) begin
      if (req_valid == 0 && exp_q.size() == 0) break;
      @(negedge clock);
      hs  = req_valid & req_ready;
      acc = acc | hs;
      @(posedge clock);
      #1;
      req_valid = req_valid & ~hs;
    end
    checks++;
    if (c >= 3000 || acc != mask) begin
      errors++;
      $display("FAIL batch: accepted=%b pending_results=%0d, required accepted=%b pending_results=0",
               acc, exp_q.size(), mask);
      exp_q.delete();
      req_valid = '0;
    end
  endtask

  initial begin
    req_valid   = 4'b1111;
    req_data    = '0;
    f_req_valid = 1'b1;
    f_req_data  = '0;
    f_res_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset_state");
    req_valid   = '0;
    f_req_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;

    run_batch(4'b0001, 32'd9);
    run_batch(4'b0001, 32'd200);
    run_batch(4'b0001, 32'd0);
    run_batch(4'b1111, {8'd255, 8'd5, 8'd4, 8'd3});

    hold_left = 10;
    run_batch(4'b1111, $urandom);

    rnd_ready = 1;
    repeat (25) run_batch(4'($urandom_range(1, 15)), $urandom);
    rnd_ready = 0;

    // Abort an operation mid-shift; the pointer must come back to 0.
    begin
      int c;
      req_data  = 32'd77;
      req_valid = 4'b0001;
      for (c = 0; c < 100; c++) begin
        @(negedge clock);
        if ((req_valid & req_ready) != 0) break;
      end
      checks++;
      if (c >= 100) begin
        errors++;
        $display("FAIL abort_grant: no grant within 100 cycles, required grant of requester 0");
      end
      @(posedge clock);
      #1;
      req_valid = 4'b0011;
      repeat (13) @(posedge clock);
      #3;
      reset = 1'b1;
      #1;
      check_zero("reset_abort");
      m_ptr = 0;
      repeat (3) @(posedge clock);
      #1;
      check_zero("reset_hold");
      reset = 1'b0;
      run_batch(4'b0011, {16'd0, 8'd10, 8'd12});
    end

    // Full 8-bit sweep on the one-bit-per-clock, single-requester instance.
    for (int v = 0; v < 256; v++) begin
      int c;
      int lat;
      f_exp_q.push_back(v % 3);
      f_req_data  = v[7:0];
      f_req_valid = 1'b1;
      for (c = 0; c < 20; c++) begin
        @(negedge clock);
        if (f_req_ready) break;
      end
      @(posedge clock);
      #1;
      f_req_valid = 1'b0;
      for (lat = 1; lat <= 20; lat++) begin
        @(posedge clock);
        #1;
        if (f_res_valid) break;
      end
      checks++;
      if (c >= 20 || lat != 8) begin
        errors++;
        $display("FAIL fast_latency: operand=%0d grant_wait=%0d latency=%0d, required grant and latency 8",
                 v, c, lat);
      end
      @(negedge clock);
      @(posedge clock);
      #1;
    end

    checks++;
    if (exp_q.size() != 0 || f_exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d and %0d expected results unseen, required 0 and 0",
               exp_q.size(), f_exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
